// File: rtl/enc_pkg.sv
// Shared types and helpers for the registered one-hot to binary stream encoder.
// Optional feature macro used by this slice: ENC_ONEHOT_CHECK_EN.
package enc_pkg;

    localparam int ENC_N_IN_DEF = 4;

    // Helpers work on a wide zero-extended vector so any legal N_IN fits.
    localparam int ENC_VEC_MAX  = 64;
    localparam int ENC_IDX_W    = $clog2(ENC_VEC_MAX);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } enc_state_t;

    function automatic logic [ENC_IDX_W-1:0] lowest_set_idx(input logic [ENC_VEC_MAX-1:0] vec);
        logic [ENC_IDX_W-1:0] idx;
        idx = '0;
        // Scanning downward lets the lowest set bit overwrite any higher one.
        for (int i = ENC_VEC_MAX - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ENC_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_multi_hot(input logic [ENC_VEC_MAX-1:0] vec);
        return (vec & (vec - ENC_VEC_MAX'(1))) != '0;
    endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO with valid/ready on both sides; head register drives the output directly.
// Ready toward the producer depends only on occupancy, never on the consumer's ready.
module enc_fifo2
    import enc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);

    enc_state_t   state_q;
    enc_state_t   state_d;
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         push_xfer;
    logic         pop_xfer;
    logic         head_load_in;
    logic         head_load_tail;
    logic         tail_load;

    assign push_ready = (state_q != FULL);
    assign pop_valid  = (state_q != EMPTY);
    assign push_xfer  = push_valid & push_ready;
    assign pop_xfer   = pop_valid & pop_ready;
    assign pop_data   = head_q;

    always_comb begin
        state_d        = state_q;
        head_load_in   = 1'b0;
        head_load_tail = 1'b0;
        tail_load      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push_xfer) begin
                    state_d      = ONE;
                    head_load_in = 1'b1;
                end
            end
            ONE: begin
                case ({push_xfer, pop_xfer})
                    2'b11: head_load_in = 1'b1;
                    2'b10: begin
                        state_d   = FULL;
                        tail_load = 1'b1;
                    end
                    2'b01: state_d = EMPTY;
                    default: ;
                endcase
            end
            FULL: begin
                if (pop_xfer) begin
                    state_d        = ONE;
                    head_load_tail = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Head only changes when it is consumed or was empty, so the output holds until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (head_load_in) begin
                head_q <= push_data;
            end else if (head_load_tail) begin
                head_q <= tail_q;
            end
            if (tail_load) begin
                tail_q <= push_data;
            end
        end
    end

endmodule

// File: rtl/encoder_4x2_stream.sv
// Registered priority encoder (bit 0 wins) with a 2-entry output buffer.
// Define ENC_ONEHOT_CHECK_EN to flag multi-hot words and count them in err_cnt.
module encoder_4x2_stream
    import enc_pkg::*;
#(
    parameter  int N_IN   = ENC_N_IN_DEF,
    localparam int CODE_W = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_zero,
    output logic              out_err,
    output logic [7:0]        err_cnt
);

    localparam int WORD_W = CODE_W + 2;

    logic [CODE_W-1:0] in_code;
    logic              in_zero;
    logic              in_err;
    logic [WORD_W-1:0] in_word;
    logic [WORD_W-1:0] out_word;
    logic              fifo_valid;
    logic              in_xfer;

    always_comb begin
        in_code = CODE_W'(lowest_set_idx(ENC_VEC_MAX'(in_vec)));
        in_zero = (in_vec == '0);
`ifdef ENC_ONEHOT_CHECK_EN
        in_err  = is_multi_hot(ENC_VEC_MAX'(in_vec));
`else
        in_err  = 1'b0;
`endif
        in_word = {in_code, in_zero, in_err};
    end

    assign in_xfer = in_valid & in_ready;

    enc_fifo2 #(
        .W (WORD_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (in_word),
        .pop_valid  (fifo_valid),
        .pop_ready  (out_ready),
        .pop_data   (out_word)
    );

    // Idle outputs read as zero so a drained buffer never shows a stale word.
    always_comb begin
        out_valid = fifo_valid;
        out_code  = '0;
        out_zero  = 1'b0;
        out_err   = 1'b0;
        if (fifo_valid) begin
            out_code = out_word[WORD_W-1:2];
            out_zero = out_word[1];
            out_err  = out_word[0];
        end
    end

`ifdef ENC_ONEHOT_CHECK_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (in_xfer && in_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_xfer;
    assign unused_xfer = in_xfer;
    assign err_cnt     = 8'd0;
`endif

endmodule

// File: tb/tb_encoder_4x2_stream.sv
// Directed self-checking bench for encoder_4x2_stream; covers both builds of ENC_ONEHOT_CHECK_EN.
module tb_encoder_4x2_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_code;
    logic       out_zero;
    logic       out_err;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    encoder_4x2_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_zero  (out_zero),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input logic valid, input logic [3:0] vec, input logic ready);
        in_valid  = valid;
        in_vec    = vec;
        out_ready = ready;
    endtask

    task automatic test_reset();
        apply_stimulus(1'b0, 4'b0000, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_code !== 2'd0 || out_zero !== 1'b0 ||
            out_err !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b code=%0d zero=%b err=%b cnt=%0d, expected all 0",
                     out_valid, out_code, out_zero, out_err, err_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_stream();
        logic [3:0] vec;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_code !== 2'(i - 1) || out_zero !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stream_word%0d: got valid=%b code=%0d zero=%b expected 1/%0d/0",
                             i - 1, out_valid, out_code, out_zero, i - 1);
                end
            end
            vec = 4'b0001 << i;
            apply_stimulus(1'b1, vec, 1'b1);
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1 || out_code !== 2'd3 || out_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_word3: got valid=%b code=%0d zero=%b expected 1/3/0",
                     out_valid, out_code, out_zero);
        end
        apply_stimulus(1'b0, 4'b0000, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_drain: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_zero();
        apply_stimulus(1'b1, 4'b0000, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_code !== 2'd0 || out_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_word: got valid=%b zero=%b code=%0d err=%b expected 1/1/0/0",
                     out_valid, out_zero, out_code, out_err);
        end
        apply_stimulus(1'b0, 4'b0000, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        apply_stimulus(1'b1, 4'b0010, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_code !== 2'd1) begin
            errors++;
            $display("[TB] FAIL bp_one: got ready=%b valid=%b code=%0d expected 1/1/1",
                     in_ready, out_valid, out_code);
        end
        apply_stimulus(1'b1, 4'b1000, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_code !== 2'd1) begin
            errors++;
            $display("[TB] FAIL bp_full: got ready=%b valid=%b code=%0d expected 0/1/1",
                     in_ready, out_valid, out_code);
        end
        apply_stimulus(1'b1, 4'b0001, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_code !== 2'd1) begin
            errors++;
            $display("[TB] FAIL bp_hold: got ready=%b code=%0d expected 0/1", in_ready, out_code);
        end
        // Offered word 0100 must be refused while FULL even though out_ready is high.
        apply_stimulus(1'b1, 4'b0100, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_code !== 2'd3) begin
            errors++;
            $display("[TB] FAIL bp_release: got ready=%b valid=%b code=%0d expected 1/1/3",
                     in_ready, out_valid, out_code);
        end
        apply_stimulus(1'b0, 4'b0000, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_no_extra: got valid=%b code=%0d expected valid 0", out_valid, out_code);
        end
    endtask

`ifdef ENC_ONEHOT_CHECK_EN
    task automatic test_onehot_check();
        logic [3:0] vec;
        apply_stimulus(1'b1, 4'b0110, 1'b1);
        @(negedge clk);
        checks++;
        if (out_code !== 2'd1 || out_err !== 1'b1 || err_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL check_0110: got code=%0d err=%b cnt=%0d expected 1/1/1",
                     out_code, out_err, err_cnt);
        end
        for (int i = 0; i < 300; i++) begin
            if (i == 200) begin
                checks++;
                if (err_cnt !== 8'd201 || out_code !== 2'd2 || out_err !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL check_mid: got cnt=%0d code=%0d err=%b expected 201/2/1",
                             err_cnt, out_code, out_err);
                end
            end
            case (i % 3)
                0:       vec = 4'b0110;
                1:       vec = 4'b1100;
                default: vec = 4'b1011;
            endcase
            apply_stimulus(1'b1, vec, 1'b1);
            @(negedge clk);
        end
        apply_stimulus(1'b0, 4'b0000, 1'b1);
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL check_saturate: got cnt=%0d expected 255", err_cnt);
        end
        @(negedge clk);
    endtask
`else
    task automatic test_onehot_off();
        apply_stimulus(1'b1, 4'b0110, 1'b1);
        @(negedge clk);
        checks++;
        if (out_code !== 2'd1 || out_err !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL nocheck_0110: got code=%0d err=%b cnt=%0d expected 1/0/0",
                     out_code, out_err, err_cnt);
        end
        apply_stimulus(1'b0, 4'b0000, 1'b1);
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        apply_stimulus(1'b1, 4'b0001, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b1, 4'b0010, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_full: got ready=%b valid=%b expected 0/1", in_ready, out_valid);
        end
        apply_stimulus(1'b0, 4'b0000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_code !== 2'd0 || err_cnt !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_async: got valid=%b code=%0d cnt=%0d ready=%b expected 0/0/0/1",
                     out_valid, out_code, err_cnt, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_stale: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        apply_stimulus(1'b1, 4'b1000, 1'b1);
        @(negedge clk);
        apply_stimulus(1'b0, 4'b0000, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_code !== 2'd3) begin
            errors++;
            $display("[TB] FAIL rst_mid_fresh: got valid=%b code=%0d expected 1/3", out_valid, out_code);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_drain: got valid=%b expected 0", out_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        apply_stimulus(1'b0, 4'b0000, 1'b0);
        test_reset();
        test_stream();
        test_zero();
        test_back_pressure();
`ifdef ENC_ONEHOT_CHECK_EN
        test_onehot_check();
`else
        test_onehot_off();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
